// File: rtl/vend_pkg.sv
// Shared types and constants for the two-panel vending-machine arbiter.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SESSION,
        WAIT_VEND,
        COOLDOWN
    } state_e;

    localparam int unsigned ONE_VAL         = 1;
    localparam int unsigned TWO_VAL         = 2;
    localparam int unsigned DEF_PRICE       = 3;
    localparam int unsigned DEF_CRED_W      = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/vend_rr_select.sv
// Two-requester round-robin picker; the pointer names the panel favoured on a tie
// and moves only when the owning session ends.
module vend_rr_select (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       pick_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d  = advance_i ? ~ptr_q : ptr_q;
        pick_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vend_panel_arbiter.sv
// Shares one vending machine between two coin panels, one purchase session at a time.
// Define VEND_TIMEOUT_EN to abort sessions that stall for TIMEOUT_CYC idle cycles.
module vend_panel_arbiter
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = DEF_PRICE,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned CRED_W      = DEF_CRED_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        p_one_in,
    input  logic [1:0]        p_two_in,
    input  logic              choco_in,
    input  logic              chng_in,
    output logic              one_out,
    output logic              two_out,
    output logic              vm_clear,
    output logic [1:0]        grant,
    output logic [1:0]        reject,
    output logic              vend_done,
    output logic              change_due,
    output logic [CRED_W-1:0] credit
);

    localparam logic [CRED_W-1:0] PriceC = CRED_W'(PRICE);
    localparam logic [CRED_W-1:0] OneC   = CRED_W'(ONE_VAL);
    localparam logic [CRED_W-1:0] TwoC   = CRED_W'(TWO_VAL);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d, reject_q, reject_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic              one_q, one_d, two_q, two_d;
    logic              vend_done_q, vend_done_d, change_due_q, change_due_d;
    logic [1:0]        coin_any;
    logic              pick, owner, accept, sess_end;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          vm_clear_q, vm_clear_d;
`endif

    assign coin_any = p_one_in | p_two_in;

    vend_rr_select u_rr (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (coin_any),
        .advance_i (sess_end),
        .pick_o    (pick)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        credit_d     = credit_q;
        reject_d     = coin_any;
        one_d        = 1'b0;
        two_d        = 1'b0;
        vend_done_d  = 1'b0;
        change_due_d = 1'b0;
        owner        = grant_q[1];
        accept       = 1'b0;
        sess_end     = 1'b0;
`ifdef VEND_TIMEOUT_EN
        timer_d      = timer_q;
        vm_clear_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|coin_any) begin
                    owner   = pick;
                    accept  = 1'b1;
                    grant_d = pick ? 2'b10 : 2'b01;
`ifdef VEND_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            SESSION: begin
                if (!choco_in) begin
                    accept = coin_any[owner];
`ifdef VEND_TIMEOUT_EN
                    if (accept) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                        if (timer_d == TW'(TIMEOUT_CYC)) begin
                            grant_d    = 2'b00;
                            credit_d   = '0;
                            vm_clear_d = 1'b1;
                            sess_end   = 1'b1;
                            timer_d    = '0;
                            state_d    = COOLDOWN;
                        end
                    end
`endif
                end
            end
            WAIT_VEND: ;
            COOLDOWN:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // A dispense ends the session whether or not the price was reached first.
        if ((state_q == SESSION || state_q == WAIT_VEND) && choco_in) begin
            grant_d      = 2'b00;
            credit_d     = '0;
            vend_done_d  = 1'b1;
            change_due_d = chng_in;
            sess_end     = 1'b1;
            state_d      = COOLDOWN;
`ifdef VEND_TIMEOUT_EN
            timer_d      = '0;
`endif
        end

        if (accept) begin
            if (p_two_in[owner]) begin
                two_d    = 1'b1;
                credit_d = credit_q + TwoC;
            end else begin
                one_d    = 1'b1;
                credit_d = credit_q + OneC;
            end
            reject_d[owner] = p_one_in[owner] & p_two_in[owner];
            state_d = (credit_d >= PriceC) ? WAIT_VEND : SESSION;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            reject_q     <= 2'b00;
            credit_q     <= '0;
            one_q        <= 1'b0;
            two_q        <= 1'b0;
            vend_done_q  <= 1'b0;
            change_due_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timer_q      <= '0;
            vm_clear_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            reject_q     <= reject_d;
            credit_q     <= credit_d;
            one_q        <= one_d;
            two_q        <= two_d;
            vend_done_q  <= vend_done_d;
            change_due_q <= change_due_d;
`ifdef VEND_TIMEOUT_EN
            timer_q      <= timer_d;
            vm_clear_q   <= vm_clear_d;
`endif
        end
    end

`ifdef VEND_TIMEOUT_EN
    assign vm_clear = vm_clear_q;
`else
    assign vm_clear = 1'b0;
`endif

    assign one_out    = one_q;
    assign two_out    = two_q;
    assign grant      = grant_q;
    assign reject     = reject_q;
    assign vend_done  = vend_done_q;
    assign change_due = change_due_q;
    assign credit     = credit_q;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter; honours VEND_TIMEOUT_EN when defined.
module tb_vend_panel_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] p_one_in = 2'b00, p_two_in = 2'b00;
    logic       choco_in = 1'b0, chng_in = 1'b0;
    logic       one_out, two_out, vm_clear, vend_done, change_due;
    logic [1:0] grant, reject;
    logic [2:0] credit;
    int         checks = 0;
    int         errors = 0;

`ifdef VEND_TIMEOUT_EN
    localparam int GAP = 10;
`else
    localparam int GAP = 99;
`endif

    vend_panel_arbiter #(.PRICE(3), .TIMEOUT_CYC(16), .CRED_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_one_in   (p_one_in),
        .p_two_in   (p_two_in),
        .choco_in   (choco_in),
        .chng_in    (chng_in),
        .one_out    (one_out),
        .two_out    (two_out),
        .vm_clear   (vm_clear),
        .grant      (grant),
        .reject     (reject),
        .vend_done  (vend_done),
        .change_due (change_due),
        .credit     (credit)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present coins for one cycle, then check the registered response.
    task automatic coin(input logic [1:0] one, input logic [1:0] two);
        p_one_in = one;
        p_two_in = two;
        step();
        p_one_in = 2'b00;
        p_two_in = 2'b00;
    endtask

    task automatic dispense(input logic chng);
        choco_in = 1'b1;
        chng_in  = chng;
        step();
        choco_in = 1'b0;
        chng_in  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if ({one_out, two_out, vm_clear, grant, reject, vend_done, change_due, credit} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {one_out, two_out, vm_clear, grant, reject, vend_done, change_due, credit});
        end
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        coin(2'b00, 2'b01);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", grant); end
        checks++;
        if ({one_out, two_out} !== 2'b01) begin
            errors++; $display("FAIL single_two_out got %b want 01", {one_out, two_out});
        end
        checks++;
        if (credit !== 3'd2) begin errors++; $display("FAIL single_credit1 got %0d want 2", credit); end
        step();
        checks++;
        if (two_out !== 1'b0) begin errors++; $display("FAIL single_pulse_len got %b want 0", two_out); end
        repeat (GAP) step();
        coin(2'b00, 2'b01);
        checks++;
        if (two_out !== 1'b1 || credit !== 3'd4) begin
            errors++; $display("FAIL single_credit2 got two=%b credit=%0d want 1/4", two_out, credit);
        end
        coin(2'b01, 2'b00);
        checks++;
        if (reject !== 2'b01 || one_out !== 1'b0 || credit !== 3'd4) begin
            errors++;
            $display("FAIL waitvend_reject got rej=%b one=%b cr=%0d want 01/0/4", reject, one_out, credit);
        end
        dispense(1'b1);
        checks++;
        if ({vend_done, change_due, grant, credit} !== 7'b1100000) begin
            errors++;
            $display("FAIL single_vend got %b want 1100000", {vend_done, change_due, grant, credit});
        end
        step();
        checks++;
        if (vend_done !== 1'b0) begin errors++; $display("FAIL vend_pulse_len got %b want 0", vend_done); end
    endtask

    task automatic test_contention();
        reset = 1'b0;
        #2 reset = 1'b1;
        step();
        coin(2'b11, 2'b00);
        checks++;
        if (grant !== 2'b01 || reject !== 2'b10 || one_out !== 1'b1 || credit !== 3'd1) begin
            errors++;
            $display("FAIL contend_first got g=%b r=%b one=%b cr=%0d want 01/10/1/1",
                     grant, reject, one_out, credit);
        end
        coin(2'b00, 2'b01);
        checks++;
        if (credit !== 3'd3) begin errors++; $display("FAIL contend_credit got %0d want 3", credit); end
        dispense(1'b0);
        checks++;
        if (vend_done !== 1'b1 || change_due !== 1'b0) begin
            errors++; $display("FAIL contend_vend got vd=%b cd=%b want 1/0", vend_done, change_due);
        end
        step();
        coin(2'b11, 2'b00);
        checks++;
        if (grant !== 2'b10 || reject !== 2'b01) begin
            errors++; $display("FAIL contend_rr got g=%b r=%b want 10/01", grant, reject);
        end
    endtask

    task automatic test_intruder();
        coin(2'b00, 2'b01);
        checks++;
        if (reject !== 2'b01 || credit !== 3'd1 || two_out !== 1'b0 || grant !== 2'b10) begin
            errors++;
            $display("FAIL intruder got r=%b cr=%0d two=%b g=%b want 01/1/0/10",
                     reject, credit, two_out, grant);
        end
    endtask

    task automatic test_double();
        coin(2'b10, 2'b10);
        checks++;
        if ({two_out, one_out, reject, credit} !== 7'b1010011) begin
            errors++;
            $display("FAIL double_coin got %b want 1010011", {two_out, one_out, reject, credit});
        end
        dispense(1'b0);
        p_one_in = 2'b01;
        step();
        p_one_in = 2'b00;
        checks++;
        if (reject !== 2'b01 || grant !== 2'b00 || one_out !== 1'b0) begin
            errors++; $display("FAIL cooldown_reject got r=%b g=%b one=%b want 01/00/0",
                               reject, grant, one_out);
        end
    endtask

    task automatic test_timeout();
        coin(2'b01, 2'b00);
        checks++;
        if (grant !== 2'b01 || credit !== 3'd1) begin
            errors++; $display("FAIL timeout_start got g=%b cr=%0d want 01/1", grant, credit);
        end
`ifdef VEND_TIMEOUT_EN
        repeat (15) step();
        checks++;
        if (vm_clear !== 1'b0 || grant !== 2'b01) begin
            errors++; $display("FAIL timeout_early got clr=%b g=%b want 0/01", vm_clear, grant);
        end
        step();
        checks++;
        if ({vm_clear, grant, credit, vend_done} !== 7'b1000000) begin
            errors++;
            $display("FAIL timeout_abort got %b want 1000000", {vm_clear, grant, credit, vend_done});
        end
        step();
        checks++;
        if (vm_clear !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", vm_clear); end
`else
        repeat (100) step();
        checks++;
        if (grant !== 2'b01 || credit !== 3'd1 || vm_clear !== 1'b0) begin
            errors++; $display("FAIL no_timeout got g=%b cr=%0d clr=%b want 01/1/0",
                               grant, credit, vm_clear);
        end
        dispense(1'b0);
        step();
`endif
    endtask

    task automatic test_async_reset();
        coin(2'b00, 2'b01);
        coin(2'b00, 2'b01);
        checks++;
        if (credit !== 3'd4) begin errors++; $display("FAIL async_setup got %0d want 4", credit); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({one_out, two_out, vm_clear, grant, reject, vend_done, change_due, credit} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got %b want 0",
                     {one_out, two_out, vm_clear, grant, reject, vend_done, change_due, credit});
        end
        #3 reset = 1'b1;
        step();
        coin(2'b10, 2'b00);
        checks++;
        if (grant !== 2'b10 || one_out !== 1'b1 || credit !== 3'd1) begin
            errors++; $display("FAIL after_reset got g=%b one=%b cr=%0d want 10/1/1",
                               grant, one_out, credit);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_intruder();
        test_double();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_panel_arbiter.md
Name: vend_panel_arbiter

Overview:
- Shares one vendingmachine instance (inputs two_in/one_in, outputs choco_out/chng_out) between two customer coin panels.
- Grants the machine to one panel per purchase session and forwards only that panel's coins.
- Rejects coins from the other panel and ends the session on the machine's dispense pulse.
- Round-robin fairness between sessions; optional inactivity timeout aborts a stalled session.

Parameters:
- PRICE, 3, chocolate price in coin units; one = 1 unit, two = 2 units.
- TIMEOUT_CYC, 16, idle cycles inside a session before abort (timeout build only).
- CRED_W, 3, credit counter width; must hold PRICE+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- p_one_in  input  2  per-panel 1-unit coin pulse; bit i = panel i; one cycle per coin.
- p_two_in  input  2  per-panel 2-unit coin pulse; one cycle per coin.
- choco_in  input  1  choco_out from vendingmachine.
- chng_in  input  1  chng_out from vendingmachine.
- one_out  output  1  to vendingmachine one_in; registered.
- two_out  output  1  to vendingmachine two_in; registered.
- vm_clear  output  1  synchronous clear request to vendingmachine; one-cycle pulse.
- grant  output  2  one-hot owner panel; 0 when idle.
- reject  output  2  one-cycle pulse per panel whose coin was not forwarded.
- vend_done  output  1  one-cycle pulse when a session ends with a dispense.
- change_due  output  1  registered copy of chng_in, qualified by vend_done.
- credit  output  CRED_W  units forwarded in the current session.

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0, rr pointer = panel 0, credit 0, timer 0.
- States: IDLE, SESSION, WAIT_VEND, COOLDOWN.
- IDLE:
  - First cycle any panel shows a coin, pick the owner: if one panel only, that panel; if both, the rr pointer panel.
  - Next cycle: grant set, the winning coin forwarded on one_out/two_out for exactly one cycle, credit += value, state SESSION.
  - Loser coin in that same cycle: reject pulse on the next cycle.
- Same panel, same cycle, one and two together: two forwarded; one rejected via reject.
- SESSION:
  - Owner coin: forwarded with 1-cycle latency; credit accumulates.
  - Non-owner coin: rejected with 1-cycle latency.
  - When credit >= PRICE after an update, go to WAIT_VEND. Further owner coins there are rejected.
- WAIT_VEND:
  - choco_in high: vend_done = 1 and change_due = chng_in next cycle, grant cleared, credit cleared, rr pointer toggles to the other panel, state COOLDOWN.
  - choco_in seen while in SESSION (machine dispensed early): handled identically.
- COOLDOWN: exactly 1 cycle; all coins rejected; then IDLE.
- one_out and two_out are never high in the same cycle; at most one forwarded coin per cycle.
- Credit range 0..PRICE+1 (overshoot from a two coin at PRICE-1); no wrap.
- Reset mid-session: immediate return to reset values; vm_clear is not pulsed (the machine shares the reset).

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined: a timer counts cycles in SESSION with no owner coin. On reaching TIMEOUT_CYC:
  - pulse vm_clear for one cycle, clear grant and credit;
  - rr pointer toggles, vend_done stays 0;
  - state COOLDOWN.
  - Timer reloads to 0 on every owner coin.
- Undefined: no timer logic; a session stays open until dispense; vm_clear tied 0.

Decomposition:
- Package vend_pkg: state enum (IDLE, SESSION, WAIT_VEND, COOLDOWN), coin value constants ONE_VAL=1 and TWO_VAL=2, default PRICE, CRED_W.
- One sub-module, vend_rr_select: 2-requester round-robin picker with a registered pointer, advanced only on session end.
- Timer stays inline under the macro.

Test Plan:
- Single panel buying: panel 0 coins two, two at 100-cycle spacing -> grant=01, two_out pulses each 1 cycle after the coin, credit 2 then 4, WAIT_VEND; choco_in=1 with chng_in=1 -> vend_done=1, change_due=1, grant=00.
- Contention: both panels pulse one in the same cycle after reset -> panel 0 granted, reject=10 next cycle. After panel 0's vend, both again -> panel 1 granted (rr toggled).
- Intruder: panel 1 session open with credit 1; panel 0 inserts two -> reject=01, credit stays 1, two_out stays 0.
- Double coin: owner asserts one and two together -> two_out=1, one_out=0, own reject bit pulses, credit += 2.
- Timeout (VEND_TIMEOUT_EN, TIMEOUT_CYC=16): one coin, then silence -> vm_clear pulses at cycle 16, grant=00, credit=0, vend_done=0. Without the macro, the session persists past 100 cycles.
- Async reset asserted mid WAIT_VEND, away from a clock edge -> all outputs 0 immediately; after release the next coin from panel 1 is granted to panel 1.
